// File: rtl/sq_pkg.sv
// sq_pkg: shared state encodings and accumulator width for seq_square_unit.
package sq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sq_state_e;

    localparam int SQ_ACC_W = 32;

endpackage

// File: rtl/cla_32.sv
// cla_32: 32-bit carry-lookahead adder built from eight 4-bit lookahead blocks.
// Block carries chain through group generate/propagate terms.
module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] s,
    output logic        c_out,
    output logic        g_out,
    output logic        p_out
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  bg;
    logic [7:0]  bp;
    logic [8:0]  bc;
    logic [8:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign bc[0] = c_in;
    assign gc[0] = 1'b0;

    for (genvar k = 0; k < 8; k++) begin : g_blk
        logic [3:0] gg;
        logic [3:0] pp;
        assign gg         = g[4*k +: 4];
        assign pp         = p[4*k +: 4];
        assign c[4*k]     = bc[k];
        assign c[4*k + 1] = gg[0] | (pp[0] & bc[k]);
        assign c[4*k + 2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & bc[k]);
        assign c[4*k + 3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & bc[k]);
        assign bg[k]      = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]);
        assign bp[k]      = &pp;
        assign bc[k + 1]  = bg[k] | (bp[k] & bc[k]);
        // carry-in-independent chain for the whole-word group generate
        assign gc[k + 1]  = bg[k] | (bp[k] & gc[k]);
    end

    assign s     = p ^ c;
    assign c_out = bc[8];
    assign g_out = gc[8];
    assign p_out = &bp;

endmodule

// File: rtl/sq_abs.sv
// sq_abs: combinational magnitude of a two's complement sample (used with SQUARE_SIGNED_EN).
// The most negative input maps to 2^(W-1), read as an unsigned W-bit value.
module sq_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] a
);

    assign a = x[W-1] ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_square_unit.sv
// seq_square_unit: iterative shift-add squarer, y = x*x, one sample per transaction.
// Build option SQUARE_SIGNED_EN: treat in_data as two's complement and square |x|.
module seq_square_unit
    import sq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SQ_ACC_W-1:0] out_data,
    output logic                busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    sq_state_e             state_q, state_d;
    logic [SQ_ACC_W-1:0]   acc_q, acc_d;
    logic [SQ_ACC_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [SQ_ACC_W-1:0]   out_data_q, out_data_d;
    logic [SQ_ACC_W-1:0]   sum;
    logic [DATA_W-1:0]     abs_x;
    logic                  last_iter;
    logic [2:0]            add_unused;

`ifdef SQUARE_SIGNED_EN
    sq_abs #(.W(DATA_W)) u_abs (
        .x (in_data),
        .a (abs_x)
    );
`else
    assign abs_x = in_data;
`endif

    cla_32 u_add (
        .a     (acc_q),
        .b     (mcand_q),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (add_unused[0]),
        .g_out (add_unused[1]),
        .p_out (add_unused[2])
    );

    // the current iteration is the last once no multiplier bits remain above bit 0
    assign last_iter = ((mplier_q >> 1) == '0) || (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d  = SQ_ACC_W'(abs_x);
                    mplier_d = abs_x;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d    = mplier_q[0] ? sum : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = last_iter ? ST_DONE : ST_CALC;
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CALC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
